fetch_stage: RTL and testbench

FETCH_STAGE -- requirements
Module: fetch_stage

---
 rtl/mips_pkg.sv | 27 ++
 rtl/irq_edge_latch.sv | 37 +++
 rtl/fetch_stage.sv | 101 ++++++++++
 tb/tb_fetch_stage.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS control encodings and exception vectors used by fetch and the control unit.
package mips_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned PCSRC_W = 3;

    typedef enum logic [PCSRC_W-1:0] {
        PCSRC_SEQ    = 3'd0,
        PCSRC_BRANCH = 3'd1,
        PCSRC_J      = 3'd2,
        PCSRC_JR     = 3'd3,
        PCSRC_ILLOP  = 3'd4,
        PCSRC_XADR   = 3'd5,
        PCSRC_RSV6   = 3'd6,
        PCSRC_RSV7   = 3'd7
    } pcsrc_e;

    localparam logic [XLEN-1:0] RESET_VEC = 32'h8000_0000;
    localparam logic [XLEN-1:0] ILLOP_VEC = 32'h8000_0004;
    localparam logic [XLEN-1:0] XADR_VEC  = 32'h8000_0008;

    // Sequential successor; the kernel bit is sticky across increments.
    function automatic logic [XLEN-1:0] seq_next(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1], pc[XLEN-2:0] + 31'd4};
    endfunction

endpackage

// File: rtl/irq_edge_latch.sv
// Rising-edge detector on irq with a sticky pending flag; set wins over clear.
module irq_edge_latch (
    input  logic clk,
    input  logic reset,
    input  logic irq,
    input  logic clr,
    output logic pending
);

    logic irq_q;
    logic pending_q;
    logic pending_d;
    logic set_c;

    always_comb begin
        set_c     = irq & ~irq_q;
        pending_d = pending_q;
        if (set_c) begin
            pending_d = 1'b1;
        end else if (clr) begin
            pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_q     <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            irq_q     <= irq;
            pending_q <= pending_d;
        end
    end

    assign pending = pending_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, next-PC selection, interrupt take and fetch counter.
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_VEC,
    parameter logic [31:0] ILLOP_PC = ILLOP_VEC,
    parameter logic [31:0] XADR_PC  = XADR_VEC
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [PCSRC_W-1:0] redirect_sel,
    input  logic [XLEN-1:0]   branch_target,
    input  logic [XLEN-1:0]   jump_target,
    input  logic [XLEN-1:0]   jr_target,
    input  logic              irq,
    output logic [XLEN-1:0]   imem_addr,
    input  logic [XLEN-1:0]   imem_rdata,
    output logic [XLEN-1:0]   pc_plus_4,
    output logic [XLEN-1:0]   instruction,
    output logic              flush_id,
    output logic              epc_we,
    output logic [XLEN-1:0]   epc_value,
    output logic [XLEN-1:0]   fetch_count
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;
    logic [XLEN-1:0] fetch_count_q;
    logic [XLEN-1:0] fetch_count_d;
    logic [XLEN-1:0] redirect_pc_c;
    logic [XLEN-1:0] seq_pc_c;
    logic            redirect_c;
    logic            take_c;
    logic            pending;

    irq_edge_latch u_irq_latch (
        .clk     (clk),
        .reset   (reset),
        .irq     (irq),
        .clr     (take_c),
        .pending (pending)
    );

    // Control-transfer decode; a valid redirect with the sequential code is a no-op.
    always_comb begin
        redirect_c    = 1'b0;
        redirect_pc_c = XADR_PC;
        take_c        = 1'b0;
        if (!reset) begin
            redirect_c = redirect_valid && (pcsrc_e'(redirect_sel) != PCSRC_SEQ);
            take_c     = pending && !pc_q[XLEN-1] && !stall && !redirect_c;
        end
        case (pcsrc_e'(redirect_sel))
            PCSRC_BRANCH: redirect_pc_c = branch_target;
            PCSRC_J:      redirect_pc_c = jump_target;
            PCSRC_JR:     redirect_pc_c = jr_target;
            PCSRC_ILLOP:  redirect_pc_c = ILLOP_PC;
            default:      redirect_pc_c = XADR_PC;
        endcase
    end

    // Next-PC priority: reset, redirect, interrupt take, stall, sequential.
    always_comb begin
        seq_pc_c      = seq_next(pc_q);
        pc_d          = seq_pc_c;
        fetch_count_d = fetch_count_q;
        if (reset) begin
            pc_d          = RESET_PC;
            fetch_count_d = '0;
        end else if (redirect_c) begin
            pc_d = redirect_pc_c;
        end else if (take_c) begin
            pc_d = ILLOP_PC;
        end else if (stall) begin
            pc_d = pc_q;
        end else begin
            fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q          <= RESET_PC;
            fetch_count_q <= '0;
        end else begin
            pc_q          <= pc_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign imem_addr   = pc_q;
    assign pc_plus_4   = seq_pc_c;
    assign instruction = (reset || redirect_c || take_c) ? '0 : imem_rdata;
    assign flush_id    = redirect_c;
    assign epc_we      = take_c;
    assign epc_value   = pc_q;
    assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: the driver queues expected per-cycle outputs, a monitor compares.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [2:0]  redirect_sel;
    logic [31:0] branch_target;
    logic [31:0] jump_target;
    logic [31:0] jr_target;
    logic        irq;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] pc_plus_4;
    logic [31:0] instruction;
    logic        flush_id;
    logic        epc_we;
    logic [31:0] epc_value;
    logic [31:0] fetch_count;

    localparam logic [31:0] ROM_KEY = 32'h5A5A_1234;

    typedef struct {
        logic [31:0] addr;
        bit          sq;
        bit          fl;
        bit          ew;
        logic [31:0] fc;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    assign imem_rdata = imem_addr ^ ROM_KEY;

    fetch_stage dut (
        .clk            (clk),
        .reset          (reset),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_sel   (redirect_sel),
        .branch_target  (branch_target),
        .jump_target    (jump_target),
        .jr_target      (jr_target),
        .irq            (irq),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .pc_plus_4      (pc_plus_4),
        .instruction    (instruction),
        .flush_id       (flush_id),
        .epc_we         (epc_we),
        .epc_value      (epc_value),
        .fetch_count    (fetch_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, req);
        end
    endtask

    // Monitor: every cycle with a queued expectation is compared at the falling edge.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            logic [31:0] p4;
            e  = exp_q.pop_front();
            p4 = {e.addr[31], e.addr[30:0] + 31'd4};
            chk("imem_addr",   imem_addr,   e.addr);
            chk("instruction", instruction, e.sq ? 32'h0 : (e.addr ^ ROM_KEY));
            chk("flush_id",    {31'd0, flush_id}, {31'd0, e.fl});
            chk("epc_we",      {31'd0, epc_we},   {31'd0, e.ew});
            chk("epc_value",   epc_value,   e.addr);
            chk("pc_plus_4",   pc_plus_4,   p4);
            chk("fetch_count", fetch_count, e.fc);
        end
    end

    // Drive one cycle of inputs, queue what the DUT must show in this cycle, advance.
    task automatic cyc(input logic rst, input logic stl, input logic rv, input logic [2:0] sel,
                       input logic [31:0] tgt, input logic irq_i,
                       input logic [31:0] e_addr, input bit e_sq, input bit e_fl,
                       input bit e_ew, input logic [31:0] e_fc);
        exp_t e;
        reset          = rst;
        stall          = stl;
        redirect_valid = rv;
        redirect_sel   = sel;
        irq            = irq_i;
        branch_target  = (sel == 3'd1) ? tgt : 32'hDEAD_0000;
        jump_target    = (sel == 3'd2) ? tgt : 32'hBEEF_0000;
        jr_target      = (sel == 3'd3) ? tgt : 32'hCAFE_0000;
        e.addr = e_addr; e.sq = e_sq; e.fl = e_fl; e.ew = e_ew; e.fc = e_fc;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_sel = 3'd0;
        branch_target = '0; jump_target = '0; jr_target = '0; irq = 1'b0;
        @(posedge clk);
        #1;
        //   rst stl rv sel tgt           irq  addr          sq fl ew fc
        // reset hold and release
        cyc(1, 0, 0, 3'd0, 32'h0,        0, 32'h8000_0000, 1, 0, 0, 32'd0);
        cyc(0, 0, 0, 3'd0, 32'h0,        0, 32'h8000_0000, 0, 0, 0, 32'd0);
        cyc(0, 0, 0, 3'd0, 32'h0,        0, 32'h8000_0004, 0, 0, 0, 32'd1);
        // jump into user space, then stall three cycles
        cyc(0, 0, 1, 3'd2, 32'h0000_0010, 0, 32'h8000_0008, 1, 1, 0, 32'd2);
        cyc(0, 1, 0, 3'd0, 32'h0,        0, 32'h0000_0010, 0, 0, 0, 32'd2);
        cyc(0, 1, 0, 3'd0, 32'h0,        0, 32'h0000_0010, 0, 0, 0, 32'd2);
        cyc(0, 1, 0, 3'd0, 32'h0,        0, 32'h0000_0010, 0, 0, 0, 32'd2);
        cyc(0, 0, 0, 3'd0, 32'h0,        0, 32'h0000_0010, 0, 0, 0, 32'd2);
        cyc(0, 0, 0, 3'd0, 32'h0,        0, 32'h0000_0014, 0, 0, 0, 32'd3);
        // branch under stall
        cyc(0, 1, 1, 3'd1, 32'h0000_0100, 0, 32'h0000_0018, 1, 1, 0, 32'd4);
        cyc(0, 0, 0, 3'd0, 32'h0,        0, 32'h0000_0100, 0, 0, 0, 32'd4);
        // redirect_valid with sel=0 is ignored
        cyc(0, 0, 1, 3'd0, 32'h0000_0400, 0, 32'h0000_0104, 0, 0, 0, 32'd5);
        // interrupt from user pc 0x20
        cyc(0, 0, 1, 3'd1, 32'h0000_0020, 0, 32'h0000_0108, 1, 1, 0, 32'd6);
        cyc(0, 0, 0, 3'd0, 32'h0,        1, 32'h0000_0020, 0, 0, 0, 32'd6);
        cyc(0, 0, 0, 3'd0, 32'h0,        1, 32'h0000_0024, 1, 0, 1, 32'd7);
        cyc(0, 0, 0, 3'd0, 32'h0,        0, 32'h8000_0004, 0, 0, 0, 32'd7);
        // kernel mask, then JR to user takes on first user cycle
        cyc(0, 0, 1, 3'd3, 32'h8000_0040, 0, 32'h8000_0008, 1, 1, 0, 32'd8);
        cyc(0, 0, 0, 3'd0, 32'h0,        1, 32'h8000_0040, 0, 0, 0, 32'd8);
        cyc(0, 0, 1, 3'd3, 32'h0000_0200, 1, 32'h8000_0044, 1, 1, 0, 32'd9);
        cyc(0, 0, 0, 3'd0, 32'h0,        0, 32'h0000_0200, 1, 0, 1, 32'd9);
        // low-bits wrap and reserved sel code
        cyc(0, 0, 1, 3'd1, 32'h7FFF_FFFC, 0, 32'h8000_0004, 1, 1, 0, 32'd9);
        cyc(0, 0, 0, 3'd0, 32'h0,        0, 32'h7FFF_FFFC, 0, 0, 0, 32'd9);
        cyc(0, 0, 0, 3'd0, 32'h0,        0, 32'h0000_0000, 0, 0, 0, 32'd10);
        cyc(0, 0, 1, 3'd7, 32'h0,        0, 32'h0000_0004, 1, 1, 0, 32'd11);
        // pending set in kernel, then reset during a redirect cancels everything
        cyc(0, 0, 0, 3'd0, 32'h0,        1, 32'h8000_0008, 0, 0, 0, 32'd11);
        cyc(1, 0, 1, 3'd1, 32'h0000_0040, 1, 32'h8000_000C, 1, 0, 0, 32'd12);
        cyc(0, 0, 0, 3'd0, 32'h0,        0, 32'h8000_0000, 0, 0, 0, 32'd0);
        cyc(0, 0, 1, 3'd2, 32'h0000_0300, 0, 32'h8000_0004, 1, 1, 0, 32'd1);
        cyc(0, 0, 0, 3'd0, 32'h0,        0, 32'h0000_0300, 0, 0, 0, 32'd1);
        // pending held across a stall, taken when stall drops
        cyc(0, 0, 0, 3'd0, 32'h0,        1, 32'h0000_0304, 0, 0, 0, 32'd2);
        cyc(0, 1, 0, 3'd0, 32'h0,        0, 32'h0000_0308, 0, 0, 0, 32'd3);
        cyc(0, 0, 0, 3'd0, 32'h0,        0, 32'h0000_0308, 1, 0, 1, 32'd3);
        cyc(0, 0, 0, 3'd0, 32'h0,        0, 32'h8000_0004, 0, 0, 0, 32'd3);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
